// File: rtl/edge_event_logger_pkg.sv
// logger_pkg: shared types and constants for the edge event logger.
//   event_t      - record layout {ts, changed, level} at the default widths
//   DEF_*        - parameter defaults used by edge_event_logger
//   CMD_*        - UART command bytes decoded upstream into start/stop/clear pulses
package logger_pkg;

   localparam int DEF_NUM_CH   = 2;
   localparam int DEF_TS_W     = 24;
   localparam int DEF_TICK_DIV = 12000;
   localparam int DEF_DEPTH    = 16;

   typedef struct packed {
      logic [DEF_TS_W-1:0]   ts;
      logic [DEF_NUM_CH-1:0] changed;
      logic [DEF_NUM_CH-1:0] level;
   } event_t;

   localparam logic [7:0] CMD_START = 8'h53;  // 'S'
   localparam logic [7:0] CMD_STOP  = 8'h54;  // 'T'
   localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
   localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'

endpackage

// File: rtl/edge_event_logger_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n   - clock, async active-low reset
//   clr          - synchronous flush (wins over push/pop)
//   push, wdata  - write; accepted when not full, or when full with a pop in the same cycle
//   pop          - read; ignored while empty
//   rdata        - head entry, valid while !empty (driven to 0 when empty)
//   count, full, empty - occupancy
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clr) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/edge_event_logger.sv
// edge_event_logger: timestamps level changes on debounced switch channels and
// queues {ts, changed_mask, new_levels} records for the dump formatter.
//   clk, rst_n                      - system clock, async active-low reset
//   sw_i                            - debounced switch levels
//   cmd_start / cmd_stop / cmd_clear - 1-cycle command pulses (clear > stop > start)
//   ev_valid / ev_ready / ev_data   - show-ahead record pop port
//   armed                           - logger is capturing
//   ev_count                        - FIFO occupancy
//   overflow                        - sticky, a record was dropped on a full FIFO
//
// state | meaning
// IDLE  | not capturing; ts and prescaler hold
// ARMED | prescaler/ts running, level changes are pushed as records
module edge_event_logger
   import logger_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int TS_W     = DEF_TS_W,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int DEPTH    = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        sw_i,
   input  logic                     cmd_start,
   input  logic                     cmd_stop,
   input  logic                     cmd_clear,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [TS_W+2*NUM_CH-1:0] ev_data,
   output logic                     armed,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     overflow
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam int            EW      = TS_W + 2 * NUM_CH;

   typedef enum logic {IDLE, ARMED} state_t;

   state_t            state;
   logic [TS_W-1:0]   ts;
   logic [PW-1:0]     prescaler;
   logic [NUM_CH-1:0] sw_q;

   logic              push;
   logic              start_fire;
   logic              pop_fire;
   logic              fifo_full;
   logic              fifo_empty;
   logic [EW-1:0]     record;

   assign armed      = (state == ARMED);
   // stop outranks start, so a coincident stop keeps the logger idle
   assign start_fire = cmd_start && !cmd_stop && (state == IDLE);
   // a coincident clear discards the event along with the FIFO contents
   assign push       = armed && (sw_i != sw_q) && !cmd_clear;
   assign pop_fire   = ev_ready && !fifo_empty;
   assign record     = {ts, sw_i ^ sw_q, sw_i};
   assign ev_valid   = !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ts        <= '0;
         prescaler <= '0;
         sw_q      <= '0;
         overflow  <= 1'b0;
      end else begin
         // tracked in every state so arming never sees a stale level
         sw_q <= sw_i;

         if (cmd_stop) begin
            state <= IDLE;
         end else if (start_fire) begin
            state <= ARMED;
         end

         if (cmd_clear || start_fire) begin
            ts        <= '0;
            prescaler <= '0;
         end else if (state == ARMED) begin
            if (prescaler == PRE_MAX) begin
               prescaler <= '0;
               ts        <= ts + 1'b1;
            end else begin
               prescaler <= prescaler + 1'b1;
            end
         end

         if (cmd_clear) begin
            overflow <= 1'b0;
         end else if (push && fifo_full && !pop_fire) begin
            overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cmd_clear),
      .push  (push),
      .wdata (record),
      .pop   (ev_ready),
      .rdata (ev_data),
      .count (ev_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
